// File: rtl/cy_fx2_pkg.sv
// FX2 slave-FIFO shared definitions: FIFOADR endpoint codes and flag polarity.
// Constants only; no latency or flow-control content.
package cy_fx2_pkg;

  typedef enum logic [1:0] {
    EP2 = 2'b00,
    EP4 = 2'b01,
    EP6 = 2'b10,
    EP8 = 2'b11
  } cy_fifoadr_e;

  localparam logic FLAG_ACTIVE = 1'b0;

  function automatic logic flag_drive(input logic asserted);
    return asserted ? FLAG_ACTIVE : ~FLAG_ACTIVE;
  endfunction

endpackage

// File: rtl/cy_ep_fifo.sv
// Byte FIFO with fall-through head, exposed pointers, count, empty and full; head is zero-latency.
// Backpressure: writes while full and reads while empty are ignored.
module cy_ep_fifo #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH) + 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_dat,
  input  logic          rd_en,
  output logic [7:0]    rd_dat,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam logic [AW-1:0] ONE = AW'(1);

  logic [7:0] mem [DEPTH];
  logic       do_wr;
  logic       do_rd;

  // MSB is the wrap bit: equal low bits with differing MSBs means full.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1] != rd_ptr[AW-1]) && (wr_ptr[AW-2:0] == rd_ptr[AW-2:0]);
  assign count  = wr_ptr - rd_ptr;
  assign do_wr  = wr_en && !full;
  assign do_rd  = rd_en && !empty;
  assign rd_dat = mem[rd_ptr[AW-2:0]];

  always_ff @(posedge sys_clk) begin
    if (do_wr) mem[wr_ptr[AW-2:0]] <= wr_dat;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + ONE;
      if (do_rd) rd_ptr <= rd_ptr + ONE;
    end
  end

endmodule

// File: rtl/cy_slave_fifo_emu.sv
// FX2 slave-FIFO device emulation: EP2 OUT fed from s_*, EP6 IN drained to m_* in committed packets.
// FD and m_* follow registered pointers with no added latency; flags lag one edge; s_ready/FLAGB/FLAGD backpressure.
module cy_slave_fifo_emu
  import cy_fx2_pkg::*;
#(
  parameter int DEPTH    = 512,
  parameter int PKT_SIZE = 512
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] cy_fd_in,
  output logic [7:0] cy_fd_out,
  output logic       cy_fd_oe,
  input  logic       cy_slrd_n,
  input  logic       cy_sloe_n,
  input  logic       cy_slwr_n,
  input  logic [1:0] cy_fifoadr,
  input  logic       cy_pktend_n,
  output logic       cy_flaga,
  output logic       cy_flagb,
  output logic       cy_flagc,
  output logic       cy_flagd,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last
);

  localparam int AW  = $clog2(DEPTH) + 1;
  localparam int BQD = DEPTH / PKT_SIZE + 4;
  localparam int BIW = $clog2(BQD);
  localparam int BCW = $clog2(BQD + 1);
  localparam logic [AW-1:0]  DEPTH_C = AW'(DEPTH);
  localparam logic [AW-1:0]  PKT_C   = AW'(PKT_SIZE);
  localparam logic [AW-1:0]  ONE     = AW'(1);
  localparam logic [BCW-1:0] BQD_C   = BCW'(BQD);

  function automatic logic [BIW-1:0] bq_next(input logic [BIW-1:0] idx);
    return (idx == BIW'(BQD - 1)) ? '0 : idx + BIW'(1);
  endfunction

  logic [7:0]    ep2_head;
  logic [AW-1:0] ep2_wr_ptr, ep2_rd_ptr, ep2_count;
  logic          ep2_empty, ep2_full, ep2_push, ep2_pop;

  assign ep2_push  = s_valid && s_ready;
  assign ep2_pop   = !cy_slrd_n && (cy_fifoadr == EP2) && !ep2_empty;
  assign s_ready   = !ep2_full;
  assign cy_fd_oe  = !cy_sloe_n && (cy_fifoadr == EP2);
  assign cy_fd_out = ep2_empty ? 8'h00 : ep2_head;

  cy_ep_fifo #(.DEPTH(DEPTH)) u_ep2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wr_en(ep2_push), .wr_dat(s_data), .rd_en(ep2_pop), .rd_dat(ep2_head),
    .wr_ptr(ep2_wr_ptr), .rd_ptr(ep2_rd_ptr), .count(ep2_count),
    .empty(ep2_empty), .full(ep2_full)
  );

  logic [7:0]     ep6_head;
  logic [AW-1:0]  ep6_wr_ptr, ep6_rd_ptr, ep6_count;
  logic           ep6_empty, ep6_full, ep6_wr, m_pop;
  logic [AW-1:0]  cm_ptr, unc, wr_nxt, unc_nxt;
  logic           pktend_now, pend_q, commit_req, do_commit;
  logic [AW-1:0]  bq [BQD];
  logic [BIW-1:0] bq_wr, bq_rd;
  logic [BCW-1:0] bq_cnt;
  logic           bq_full, bq_pop;

  // Writes stall at a full packet so an auto-commit blocked by a full boundary queue never overshoots.
  assign unc        = ep6_wr_ptr - cm_ptr;
  assign ep6_wr     = !cy_slwr_n && (cy_fifoadr == EP6) && !ep6_full && (unc < PKT_C);
  assign wr_nxt     = ep6_wr ? ep6_wr_ptr + ONE : ep6_wr_ptr;
  assign unc_nxt    = wr_nxt - cm_ptr;
  assign pktend_now = !cy_pktend_n && (cy_fifoadr == EP6);
  assign bq_full    = (bq_cnt == BQD_C);
  assign commit_req = (unc_nxt >= PKT_C) || pktend_now || pend_q;
  assign do_commit  = commit_req && (unc_nxt != '0) && !bq_full;

  assign m_valid = (cm_ptr != ep6_rd_ptr);
  assign m_data  = m_valid ? ep6_head : 8'h00;
  assign m_last  = m_valid && ((ep6_rd_ptr + ONE) == bq[bq_rd]);
  assign m_pop   = m_valid && m_ready;
  assign bq_pop  = m_pop && m_last;

  cy_ep_fifo #(.DEPTH(DEPTH)) u_ep6 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wr_en(ep6_wr), .wr_dat(cy_fd_in), .rd_en(m_pop), .rd_dat(ep6_head),
    .wr_ptr(ep6_wr_ptr), .rd_ptr(ep6_rd_ptr), .count(ep6_count),
    .empty(ep6_empty), .full(ep6_full)
  );

  logic unused_ok;
  assign unused_ok = ^{ep2_wr_ptr, ep2_rd_ptr, ep6_empty};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cm_ptr   <= '0;
      pend_q   <= 1'b0;
      bq_wr    <= '0;
      bq_rd    <= '0;
      bq_cnt   <= '0;
      for (int i = 0; i < BQD; i++) bq[i] <= '0;
      cy_flaga <= flag_drive(1'b1);
      cy_flagb <= flag_drive(1'b0);
      cy_flagc <= flag_drive(1'b1);
      cy_flagd <= flag_drive(1'b0);
    end else begin
      if (do_commit) begin
        cm_ptr    <= wr_nxt;
        bq[bq_wr] <= wr_nxt;
        bq_wr     <= bq_next(bq_wr);
      end
      if (bq_pop) bq_rd <= bq_next(bq_rd);
      if (do_commit && !bq_pop)      bq_cnt <= bq_cnt + BCW'(1);
      else if (!do_commit && bq_pop) bq_cnt <= bq_cnt - BCW'(1);
      pend_q   <= (pktend_now || pend_q) && !do_commit && (unc_nxt != '0);
      cy_flaga <= flag_drive(ep2_count == '0);
      cy_flagb <= flag_drive(ep6_count == DEPTH_C);
      cy_flagc <= flag_drive(cm_ptr == ep6_rd_ptr);
      cy_flagd <= flag_drive(ep2_count == DEPTH_C);
    end
  end

endmodule

// File: tb/tb_cy_slave_fifo_emu.sv
// Bench for cy_slave_fifo_emu: queue-level reference model compared every cycle, directed
// scenarios with literal expectations, then randomized strobes and stream traffic.
module tb_cy_slave_fifo_emu;

  localparam int DEPTH = 512;
  localparam int PKT   = 512;
  localparam int BQD   = DEPTH / PKT + 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] cy_fd_in = 8'h00;
  logic [7:0] cy_fd_out;
  logic       cy_fd_oe;
  logic       cy_slrd_n = 1'b1;
  logic       cy_sloe_n = 1'b1;
  logic       cy_slwr_n = 1'b1;
  logic [1:0] cy_fifoadr = 2'b00;
  logic       cy_pktend_n = 1'b1;
  logic       cy_flaga, cy_flagb, cy_flagc, cy_flagd;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       m_last;

  cy_slave_fifo_emu #(.DEPTH(DEPTH), .PKT_SIZE(PKT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cy_fd_in(cy_fd_in), .cy_fd_out(cy_fd_out), .cy_fd_oe(cy_fd_oe),
    .cy_slrd_n(cy_slrd_n), .cy_sloe_n(cy_sloe_n), .cy_slwr_n(cy_slwr_n),
    .cy_fifoadr(cy_fifoadr), .cy_pktend_n(cy_pktend_n),
    .cy_flaga(cy_flaga), .cy_flagb(cy_flagb), .cy_flagc(cy_flagc), .cy_flagd(cy_flagd),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: EP2 byte queue; EP6 split into uncommitted bytes and committed bytes with end marks.
  logic [7:0] ep2_q[$];
  logic [7:0] unc_q[$];
  logic [7:0] com_d[$];
  bit         com_l[$];
  int         npk  = 0;
  bit         pend = 1'b0;
  bit         fa = 1'b0, fb = 1'b1, fc = 1'b0, fd = 1'b1;

  task automatic model_reset();
    ep2_q.delete(); unc_q.delete(); com_d.delete(); com_l.delete();
    npk = 0; pend = 1'b0;
    fa = 1'b0; fb = 1'b1; fc = 1'b0; fd = 1'b1;
  endtask

  task automatic model_step();
    int   total;
    bit   rd2, wr2, wr6, bq_was_full, pkt_now, req, lastbit;
    logic [7:0] b;
    total = com_d.size() + unc_q.size();
    fa = (ep2_q.size() != 0);
    fb = (total != DEPTH);
    fc = (com_d.size() != 0);
    fd = (ep2_q.size() != DEPTH);
    rd2 = !cy_slrd_n && cy_fifoadr == 2'b00 && ep2_q.size() > 0;
    wr2 = s_valid && ep2_q.size() < DEPTH;
    if (rd2) void'(ep2_q.pop_front());
    if (wr2) ep2_q.push_back(s_data);
    bq_was_full = (npk >= BQD);
    wr6 = !cy_slwr_n && cy_fifoadr == 2'b10 && total < DEPTH && unc_q.size() < PKT;
    if (m_ready && com_d.size() > 0) begin
      void'(com_d.pop_front());
      lastbit = com_l.pop_front();
      if (lastbit) npk--;
    end
    if (wr6) unc_q.push_back(cy_fd_in);
    pkt_now = !cy_pktend_n && cy_fifoadr == 2'b10;
    req = pend || pkt_now || unc_q.size() >= PKT;
    if (req && unc_q.size() > 0 && !bq_was_full) begin
      while (unc_q.size() > 0) begin
        b = unc_q.pop_front();
        com_d.push_back(b);
        com_l.push_back(unc_q.size() == 0);
      end
      npk++;
      pend = 1'b0;
    end else begin
      pend = (pend || pkt_now) && unc_q.size() > 0;
    end
  endtask

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) model_reset();
    else         model_step();
  end

  always @(negedge sys_clk) begin
    #2;
    chk("fd_oe", int'(cy_fd_oe), int'(!cy_sloe_n && cy_fifoadr == 2'b00));
    chk("fd_out", int'(cy_fd_out), ep2_q.size() > 0 ? int'(ep2_q[0]) : 0);
    chk("s_ready", int'(s_ready), int'(ep2_q.size() < DEPTH));
    chk("m_valid", int'(m_valid), int'(com_d.size() > 0));
    if (com_d.size() > 0) begin
      chk("m_data", int'(m_data), int'(com_d[0]));
      chk("m_last", int'(m_last), int'(com_l[0]));
    end else begin
      chk("m_last_idle", int'(m_last), 0);
    end
    chk("flaga", int'(cy_flaga), int'(fa));
    chk("flagb", int'(cy_flagb), int'(fb));
    chk("flagc", int'(cy_flagc), int'(fc));
    chk("flagd", int'(cy_flagd), int'(fd));
  end

  task automatic idle();
    cy_slrd_n = 1'b1; cy_sloe_n = 1'b1; cy_slwr_n = 1'b1; cy_pktend_n = 1'b1;
    cy_fifoadr = 2'b00; s_valid = 1'b0; m_ready = 1'b0;
  endtask

  initial begin
    bit seen;
    idle();
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    #3;
    chk("rst_flaga", int'(cy_flaga), 0);
    chk("rst_flagb", int'(cy_flagb), 1);
    chk("rst_flagc", int'(cy_flagc), 0);
    chk("rst_flagd", int'(cy_flagd), 1);
    chk("rst_fd_oe", int'(cy_fd_oe), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_s_ready", int'(s_ready), 1);

    // EP2: host pushes three bytes, master reads them back-to-back plus one extra read.
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk); s_valid = 1'b1; s_data = 8'(8'h11 * (i + 1));
    end
    @(negedge sys_clk);
    s_valid = 1'b0; cy_sloe_n = 1'b0; cy_fifoadr = 2'b00; cy_slrd_n = 1'b0;
    #3 chk("rd0", int'(cy_fd_out), 'h11); chk("rd_oe", int'(cy_fd_oe), 1);
    @(negedge sys_clk); #3 chk("rd1", int'(cy_fd_out), 'h22);
    @(negedge sys_clk); #3 chk("rd2", int'(cy_fd_out), 'h33);
    @(negedge sys_clk); #3 chk("rd_empty", int'(cy_fd_out), 0);
    @(negedge sys_clk); idle();
    #3 chk("flaga_after_pop", int'(cy_flaga), 0); chk("s_ready_after_rd", int'(s_ready), 1);

    // EP6: five writes, then PKTEND, then drain.
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk); cy_fifoadr = 2'b10; cy_slwr_n = 1'b0; cy_fd_in = 8'(8'hA0 + i);
    end
    @(negedge sys_clk); cy_slwr_n = 1'b1;
    #3 chk("m_valid_uncommitted", int'(m_valid), 0);
    @(negedge sys_clk); cy_pktend_n = 1'b0;
    #3 chk("m_valid_before_commit", int'(m_valid), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk); cy_pktend_n = 1'b1; m_ready = 1'b1;
      #3 chk("pkt_data", int'(m_data), 'hA0 + i);
      chk("pkt_last", int'(m_last), int'(i == 4));
      if (i == 1) chk("flagc_committed", int'(cy_flagc), 1);
    end
    @(negedge sys_clk); m_ready = 1'b0;
    #3 chk("m_valid_drained", int'(m_valid), 0);
    @(negedge sys_clk); #3 chk("flagc_drained", int'(cy_flagc), 0);

    // EP6: fill to DEPTH with no host pops; auto-commit, full flag, dropped write.
    for (int i = 0; i < 512; i++) begin
      @(negedge sys_clk); cy_fifoadr = 2'b10; cy_slwr_n = 1'b0; cy_fd_in = 8'(i);
    end
    @(negedge sys_clk); cy_fd_in = 8'hEE;
    #3 chk("auto_commit_valid", int'(m_valid), 1); chk("auto_commit_head", int'(m_data), 0);
    @(negedge sys_clk); cy_slwr_n = 1'b1;
    #3 chk("flagb_full", int'(cy_flagb), 0);
    @(negedge sys_clk); m_ready = 1'b1;
    @(negedge sys_clk); m_ready = 1'b0;
    @(negedge sys_clk); #3 chk("flagb_after_pop", int'(cy_flagb), 1);
    seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge sys_clk); m_ready = 1'b1;
      #3;
      if (m_last) begin
        chk("auto_pkt_last_byte", int'(m_data), 'hFF);
        seen = 1'b1;
      end
    end
    chk("auto_pkt_last_seen", int'(seen), 1);
    @(negedge sys_clk); idle();

    // EP2: host fills to full, then a push+pop cycle at full.
    for (int i = 0; i < 512; i++) begin
      @(negedge sys_clk); s_valid = 1'b1; s_data = 8'($urandom);
    end
    @(negedge sys_clk);
    cy_sloe_n = 1'b0; cy_fifoadr = 2'b00; cy_slrd_n = 1'b0;
    #3 chk("s_ready_full", int'(s_ready), 0);
    @(negedge sys_clk); cy_slrd_n = 1'b1;
    #3 chk("s_ready_511", int'(s_ready), 1); chk("flagd_full", int'(cy_flagd), 0);
    @(negedge sys_clk); s_valid = 1'b0;
    #3 chk("s_ready_refull", int'(s_ready), 0);
    cy_slrd_n = 1'b0;
    repeat (512) @(negedge sys_clk);
    idle();
    #3 chk("ep2_drained_fd", int'(cy_fd_out), 0);

    // Reset in the middle of traffic.
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk); s_valid = 1'b1; s_data = 8'(8'h5A + i);
    end
    @(negedge sys_clk); s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk); cy_fifoadr = 2'b10; cy_slwr_n = 1'b0; cy_fd_in = 8'(8'hC0 + i);
    end
    @(negedge sys_clk); idle();
    #3 chk("flaga_pre_rst", int'(cy_flaga), 1);
    @(negedge sys_clk); sys_rst = 1'b1;
    #3 chk("mid_rst_flaga", int'(cy_flaga), 0);
    chk("mid_rst_flagb", int'(cy_flagb), 1);
    chk("mid_rst_flagc", int'(cy_flagc), 0);
    chk("mid_rst_flagd", int'(cy_flagd), 1);
    chk("mid_rst_fd_out", int'(cy_fd_out), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    #3 chk("post_rst_m_valid", int'(m_valid), 0);
    chk("post_rst_flagc", int'(cy_flagc), 0);
    chk("post_rst_flaga", int'(cy_flaga), 0);

    // Randomized traffic; even phases starve the host side so packets pile up.
    for (int c = 0; c < 4000; c++) begin
      @(negedge sys_clk);
      if ((c / 1000) % 2 == 0) begin
        m_ready = ($urandom_range(0, 9) < 1);
        s_valid = ($urandom_range(0, 9) < 7);
      end else begin
        m_ready = ($urandom_range(0, 9) < 8);
        s_valid = ($urandom_range(0, 9) < 3);
      end
      cy_fifoadr  = 2'($urandom);
      cy_slrd_n   = 1'($urandom);
      cy_sloe_n   = 1'($urandom);
      cy_slwr_n   = ($urandom_range(0, 3) == 0);
      cy_pktend_n = ($urandom_range(0, 7) != 0);
      cy_fd_in    = 8'($urandom);
      s_data      = 8'($urandom);
    end
    @(negedge sys_clk); idle();
    repeat (2) @(negedge sys_clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cy_slave_fifo_emu.md
Name: cy_slave_fifo_emu

Overview:
- Synthesizable model of the CY7C68013 (FX2) synchronous slave-FIFO device side. It responds to the FPGA master strobes SLRD, SLOE, SLWR, FIFOADR and PKTEND.
- It drives the 8-bit FD bus and FLAGA..D, using the same flag meanings the master-side logic checks for its idle "buffok" condition.
- It holds two internal byte FIFOs:
  - EP2 OUT (host to master), filled from a local stream input.
  - EP6 IN (master to host), drained to a local stream output with packet boundaries.
- It is used for board-level loopback and for simulation of the master without a real FX2.

Parameters:
- DEPTH, 512, bytes per endpoint FIFO (power of two).
- PKT_SIZE, 512, EP6 auto-commit packet length in bytes (at most DEPTH).

Ports:
- sys_clk  in  1  single clock; IFCLK-equivalent, all logic on its rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- cy_fd_in  in  8  FD bus as driven by the master.
- cy_fd_out  out  8  FD bus value from the EP2 head.
- cy_fd_oe  out  1  1 = this block drives FD.
- cy_slrd_n  in  1  read strobe, active low.
- cy_sloe_n  in  1  output enable, active low.
- cy_slwr_n  in  1  write strobe, active low.
- cy_fifoadr  in  2  00 = EP2; 10 = EP6; other codes select nothing.
- cy_pktend_n  in  1  packet end, active low.
- cy_flaga  out  1  EP2 empty, active low.
- cy_flagb  out  1  EP6 full, active low.
- cy_flagc  out  1  EP6 empty, active low.
- cy_flagd  out  1  EP2 full, active low.
- s_data  in  8  host stream into EP2.
- s_valid  in  1  host stream valid.
- s_ready  out  1  EP2 not full.
- m_data  out  8  EP6 committed byte to host.
- m_valid  out  1  committed data available.
- m_ready  in  1  host accepts the byte.
- m_last  out  1  last byte of the committed packet.

Behaviour:
- Reset: both FIFOs empty, commit pointer 0, cy_fd_oe=0, cy_fd_out=0, s_ready=1, m_valid=0, m_last=0. Flags at reset: FLAGA=0, FLAGB=1, FLAGC=0, FLAGD=1.
- cy_fd_oe = !cy_sloe_n && cy_fifoadr==00, combinational.
- cy_fd_out = EP2 head byte. It is 0 when EP2 is empty.
- EP2 pop: on a rising edge with cy_slrd_n=0, fifoadr=00 and EP2 not empty.
  - The new head is visible after that edge (zero-wait consecutive reads).
  - SLRD while EP2 is empty is ignored and no underflow occurs.
- EP2 push: when s_valid && s_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - With EP2 empty and both asserted, only the push happens.
- EP6 write: on a rising edge with cy_slwr_n=0, fifoadr=10 and EP6 not full, cy_fd_in is stored. SLWR while EP6 is full is dropped.
- Strobes with an unselected fifoadr, or SLWR at 00 / SLRD at 10, have no effect.
- EP6 commit: written bytes become visible to m_* only when committed. A commit occurs when either:
  - the uncommitted count reaches PKT_SIZE, or
  - cy_pktend_n=0 with fifoadr=10 and the uncommitted count > 0.
- PKTEND coinciding with a write commits that byte too. PKTEND with zero uncommitted bytes is ignored (no zero-length packets).
- Each commit records its end position in a boundary queue of depth DEPTH/PKT_SIZE + 4.
  - If that queue is full, PKTEND is held pending until a slot frees.
  - Auto-commit never exceeds the queue depth.
- m_data/m_valid are registered FWFT. m_last=1 on the byte at a recorded boundary. A pop occurs on m_valid && m_ready.
- Flags come from registered counts and reflect a change on the edge after the pointer change:
  - FLAGC=0 while EP6 has no committed data.
  - FLAGB=0 while the EP6 total occupancy (committed + uncommitted) equals DEPTH.
- Pointers are AW=$clog2(DEPTH)+1 bits, with the MSB used for wrap. Full = MSBs differ and the rest are equal.
- Reset asserted mid-transfer discards all contents and pending packets immediately.

Decomposition:
- Shared package cy_fx2_pkg: FIFOADR codes EP2=2'b00, EP4=2'b01, EP6=2'b10, EP8=2'b11; flag polarity constant (active low).
- One natural sub-module, cy_ep_fifo: a parameterized byte FIFO with count, empty and full. It is instantiated twice.
- EP6 adds the commit pointer, packet counter and boundary queue at this level.

Test Plan:
- Idle after reset -> FLAGA=0, FLAGB=1, FLAGC=0, FLAGD=1, cy_fd_oe=0, m_valid=0.
- Host pushes 0x11,0x22,0x33; master holds SLOE=0, addr=00 and SLRD=0 for 3 cycles -> FD reads 11,22,33; FLAGA=0 the cycle after the last pop; a 4th SLRD leaves the state unchanged.
- Master writes 5 bytes 0xA0..0xA4 with addr=10, then PKTEND -> m_valid only after PKTEND; host receives A0..A4 with m_last only on A4; FLAGC goes 1 then 0.
- Master writes 512 bytes with m_ready=0 -> auto-commit at byte 512; FLAGB=0; a 513th SLWR is dropped; after one host pop FLAGB=1 next cycle.
- Host pushes 512 bytes -> s_ready=0, FLAGD=0; simultaneous s_valid and SLRD pop at full -> count stays 511 after one push+pop cycle.
- Reset asserted after 3 uncommitted EP6 writes and 2 EP2 bytes -> all flags return to idle values, and m_valid stays 0 after reset is released.
